// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types, constants and CRC-32 step function for the Ethernet RX path
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_DONE
    } parser_state_t;

    localparam int ETH_HDR_LEN = 14;
    localparam int ETH_FCS_LEN = 4;

    localparam logic [31:0] CRC32_POLY        = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT        = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE     = 32'hDEBB_20E3;
    localparam logic [47:0] ETH_BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

    // Reflected CRC-32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// rtl/eth_crc32.sv - byte-wide CRC-32 register with clear and enable
module eth_crc32
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc,
    output logic [31:0] crc_upd
);

    // crc_upd includes the current byte so a caller can judge the frame in the same cycle it clears.
    assign crc_upd = en ? crc32_next(crc, data) : crc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= CRC32_INIT;
        end else if (clr) begin
            crc <= CRC32_INIT;
        end else begin
            crc <= crc_upd;
        end
    end

endmodule

// File: rtl/ethernet_frame_parser.sv
// rtl/ethernet_frame_parser.sv - Ethernet II header/payload splitter with CRC and length check; optional ETH_MAC_FILTER_EN
module ethernet_frame_parser
    import eth_pkg::*;
#(
    parameter int          MAX_FRAME_LEN = 1518,
    parameter int          MIN_FRAME_LEN = 64,
    parameter logic [47:0] LOCAL_MAC     = 48'h02_00_00_00_00_01
) (
    input  logic        eth_rx_clk,
    input  logic        eth_rx_rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_byte_valid,
    input  logic        frame_active,
    output logic [47:0] dst_mac,
    output logic [47:0] src_mac,
    output logic [15:0] ethertype,
    output logic        hdr_valid,
    output logic [7:0]  payload_byte,
    output logic        payload_valid,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic        addr_miss,
    output logic [10:0] frame_len
);

`ifdef ETH_MAC_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    localparam logic [10:0] HDR_LAST  = 11'(ETH_HDR_LEN - 1);
    localparam logic [10:0] PAY_START = 11'(ETH_HDR_LEN + ETH_FCS_LEN);
    localparam logic [10:0] LEN_MIN   = 11'(MIN_FRAME_LEN);
    localparam logic [10:0] LEN_MAX   = 11'(MAX_FRAME_LEN);
    localparam logic [10:0] LEN_SAT   = 11'(MAX_FRAME_LEN + 1);

    parser_state_t state, state_nxt;
    logic          accept, frame_end, fall, fa_prev, armed;
    logic [10:0]   byte_cnt, cnt_nxt;
    logic [103:0]  hdr_sr;
    logic [111:0]  hdr_full;
    logic [7:0]    dl [4];
    logic          hdr_load, emit, dst_miss, filt_miss, len_bad;
    logic [31:0]   crc, crc_upd;

    assign fall     = fa_prev && !frame_active;
    assign hdr_full = {hdr_sr, rx_byte};
    assign cnt_nxt  = (accept && byte_cnt != LEN_SAT) ? byte_cnt + 11'd1 : byte_cnt;
    assign len_bad  = (cnt_nxt < LEN_MIN) || (cnt_nxt > LEN_MAX);
    assign hdr_load = accept && (state == ST_HEADER) && (byte_cnt == HDR_LAST) && !fall;
    assign emit     = accept && (state == ST_PAYLOAD) && (byte_cnt >= PAY_START)
                      && (cnt_nxt <= LEN_MAX) && !filt_miss;
    assign dst_miss = FILTER_EN && (hdr_full[111:64] != LOCAL_MAC)
                      && (hdr_full[111:64] != ETH_BROADCAST_MAC);

    always_ff @(posedge eth_rx_clk or posedge eth_rx_rst) begin
        if (eth_rx_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DONE accepts a new first byte exactly like IDLE so back-to-back frames are not lost.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        frame_end = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (armed && frame_active && rx_byte_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_HEADER;
                end
            end
            ST_HEADER: begin
                accept = rx_byte_valid;
                if (fall) begin
                    frame_end = 1'b1;
                    state_nxt = ST_DONE;
                end else if (rx_byte_valid && byte_cnt == HDR_LAST) begin
                    state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                accept = rx_byte_valid;
                if (fall) begin
                    frame_end = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    eth_crc32 u_crc (
        .clk     (eth_rx_clk),
        .rst     (eth_rx_rst),
        .clr     (frame_end),
        .en      (accept),
        .data    (rx_byte),
        .crc     (crc),
        .crc_upd (crc_upd)
    );

    always_ff @(posedge eth_rx_clk or posedge eth_rx_rst) begin
        if (eth_rx_rst) begin
            fa_prev       <= 1'b0;
            armed         <= 1'b0;
            byte_cnt      <= '0;
            hdr_sr        <= '0;
            for (int i = 0; i < 4; i++) dl[i] <= '0;
            filt_miss     <= 1'b0;
            dst_mac       <= '0;
            src_mac       <= '0;
            ethertype     <= '0;
            hdr_valid     <= 1'b0;
            payload_byte  <= '0;
            payload_valid <= 1'b0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            crc_err       <= 1'b0;
            len_err       <= 1'b0;
            addr_miss     <= 1'b0;
            frame_len     <= '0;
        end else begin
            fa_prev <= frame_active;
            // Stay disarmed until the line is seen idle, so a frame cut by reset is never picked up.
            armed   <= armed || !frame_active;
            byte_cnt <= frame_end ? '0 : cnt_nxt;
            if (accept) begin
                hdr_sr <= hdr_full[103:0];
                dl[0]  <= rx_byte;
                dl[1]  <= dl[0];
                dl[2]  <= dl[1];
                dl[3]  <= dl[2];
            end
            if (frame_end) begin
                filt_miss <= 1'b0;
            end else if (hdr_load) begin
                filt_miss <= dst_miss;
            end
            hdr_valid <= hdr_load;
            if (hdr_load) begin
                dst_mac   <= hdr_full[111:64];
                src_mac   <= hdr_full[63:16];
                ethertype <= hdr_full[15:0];
            end
            payload_valid <= emit;
            if (emit) begin
                payload_byte <= dl[3];
            end
            frame_done <= frame_end;
            crc_err    <= frame_end && (crc_upd != CRC32_RESIDUE);
            len_err    <= frame_end && len_bad;
            addr_miss  <= frame_end && filt_miss;
            frame_ok   <= frame_end && (crc_upd == CRC32_RESIDUE) && !len_bad && !filt_miss;
            frame_len  <= frame_end ? cnt_nxt : '0;
        end
    end

endmodule

// File: tb/tb_ethernet_frame_parser.sv
// tb/tb_ethernet_frame_parser.sv - scoreboard bench for ethernet_frame_parser
module tb_ethernet_frame_parser;

`ifdef ETH_MAC_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif
    localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_byte = '0;
    logic        rx_byte_valid = 1'b0;
    logic        frame_active = 1'b0;
    logic [47:0] dst_mac, src_mac;
    logic [15:0] ethertype;
    logic        hdr_valid, payload_valid, frame_done, frame_ok, crc_err, len_err, addr_miss;
    logic [7:0]  payload_byte;
    logic [10:0] frame_len;

    int errors = 0;
    int checks = 0;

    logic [7:0]   frm[$];
    logic [7:0]   pay_q[$];
    logic [111:0] hdr_q[$];
    logic [14:0]  st_q[$];

    always #5 clk = ~clk;

    ethernet_frame_parser dut (
        .eth_rx_clk    (clk),
        .eth_rx_rst    (rst),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .frame_active  (frame_active),
        .dst_mac       (dst_mac),
        .src_mac       (src_mac),
        .ethertype     (ethertype),
        .hdr_valid     (hdr_valid),
        .payload_byte  (payload_byte),
        .payload_valid (payload_valid),
        .frame_done    (frame_done),
        .frame_ok      (frame_ok),
        .crc_err       (crc_err),
        .len_err       (len_err),
        .addr_miss     (addr_miss),
        .frame_len     (frame_len)
    );

    task automatic chk(input string tag, input logic [111:0] got, input logic [111:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bench-side CRC: xor the byte into the low bits, then eight shift/reduce steps.
    function automatic logic [31:0] model_crc(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, frm[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic build(input logic [47:0] da, input logic [47:0] sa, input logic [15:0] et, input int plen);
        logic [31:0] fcs;
        frm.delete();
        for (int i = 5; i >= 0; i--) frm.push_back(da[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) frm.push_back(sa[i*8 +: 8]);
        frm.push_back(et[15:8]);
        frm.push_back(et[7:0]);
        for (int i = 0; i < plen; i++) frm.push_back(8'(i));
        fcs = ~model_crc(frm.size());
        for (int i = 0; i < 4; i++) frm.push_back(fcs[i*8 +: 8]);
    endtask

    task automatic expect_frame();
        int len, last;
        logic [111:0] hdr;
        logic miss, lbad, cbad;
        len  = frm.size();
        miss = 1'b0;
        if (len >= 14) begin
            hdr = '0;
            for (int i = 0; i < 14; i++) hdr = {hdr[103:0], frm[i]};
            hdr_q.push_back(hdr);
            miss = FILTER_ON && (hdr[111:64] != MY_MAC) && (hdr[111:64] != BCAST);
            last = ((len > 1518) ? 1518 : len) - 5;
            if (!miss) for (int i = 14; i <= last; i++) pay_q.push_back(frm[i]);
        end
        lbad = (len < 64) || (len > 1518);
        cbad = (model_crc(len) != 32'hDEBB_20E3);
        st_q.push_back({!lbad && !cbad && !miss, cbad, lbad, miss, 11'((len > 1519) ? 1519 : len)});
    endtask

    task automatic send_bytes(input int n, input bit fall_last);
        @(posedge clk); #1 frame_active = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 rx_byte = frm[i]; rx_byte_valid = 1'b1;
            if (fall_last && i == n - 1) frame_active = 1'b0;
            @(posedge clk); #1 rx_byte_valid = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        repeat (6) @(posedge clk);
        chk({tag, "_payq"}, 112'(pay_q.size()), 112'd0);
        chk({tag, "_hdrq"}, 112'(hdr_q.size()), 112'd0);
        chk({tag, "_stq"},  112'(st_q.size()),  112'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hdr"}, {dst_mac, src_mac, ethertype}, 112'd0);
        chk({tag, "_pulses"}, 112'({hdr_valid, payload_valid, frame_done, payload_byte}), 112'd0);
        chk({tag, "_status"}, 112'({frame_ok, crc_err, len_err, addr_miss, frame_len}), 112'd0);
    endtask

    // Scoreboard side: every DUT output event must match the head of its queue.
    always @(negedge clk) begin
        if (payload_valid) begin
            chk("payload_expected", 112'(pay_q.size() != 0), 112'd1);
            if (pay_q.size() != 0) chk("payload_byte", 112'(payload_byte), 112'(pay_q.pop_front()));
        end
        if (hdr_valid) begin
            chk("hdr_expected", 112'(hdr_q.size() != 0), 112'd1);
            if (hdr_q.size() != 0) chk("hdr_fields", {dst_mac, src_mac, ethertype}, hdr_q.pop_front());
        end
        if (frame_done) begin
            chk("done_expected", 112'(st_q.size() != 0), 112'd1);
            if (st_q.size() != 0)
                chk("frame_status", 112'({frame_ok, crc_err, len_err, addr_miss, frame_len}), 112'(st_q.pop_front()));
        end else begin
            chk("status_idle", 112'({frame_ok, crc_err, len_err, addr_miss}), 112'd0);
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Good 64-byte broadcast frame.
        build(BCAST, 48'h02_00_00_00_00_AA, 16'h0800, 46);
        expect_frame();
        send_bytes(64, 1'b0); frame_active = 1'b0;
        drain("good64");

        // Same frame with one payload bit flipped.
        build(BCAST, 48'h02_00_00_00_00_AA, 16'h0800, 46);
        frm[20] = frm[20] ^ 8'h10;
        expect_frame();
        send_bytes(64, 1'b0); frame_active = 1'b0;
        drain("crcbad");

        // Runt with valid FCS.
        build(BCAST, 48'h02_00_00_00_00_AA, 16'h0800, 22);
        expect_frame();
        send_bytes(40, 1'b0); frame_active = 1'b0;
        drain("runt40");

        // Oversize 1519-byte frame.
        build(BCAST, 48'h02_00_00_00_00_AA, 16'h0800, 1501);
        expect_frame();
        send_bytes(1519, 1'b0); frame_active = 1'b0;
        drain("over1519");

        // Fall during header after 10 bytes.
        build(BCAST, 48'h02_00_00_00_00_AA, 16'h0800, 46);
        while (frm.size() > 10) void'(frm.pop_back());
        expect_frame();
        send_bytes(10, 1'b0); frame_active = 1'b0;
        drain("hdrfall");

        // Reset mid-payload: only the bytes already emitted are expected.
        build(BCAST, 48'h02_00_00_00_00_AA, 16'h0800, 46);
        begin
            logic [111:0] h;
            h = '0;
            for (int i = 0; i < 14; i++) h = {h[103:0], frm[i]};
            hdr_q.push_back(h);
            for (int i = 14; i <= 25; i++) pay_q.push_back(frm[i]);
        end
        send_bytes(30, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset");
        @(posedge clk); #1 rst = 1'b0;
        send_bytes(8, 1'b0); frame_active = 1'b0;
        drain("midreset");

        // Back-to-back: first frame's last byte lands on the fall cycle, line low one cycle.
        build(BCAST, 48'h02_00_00_00_00_AA, 16'h0800, 46);
        expect_frame();
        send_bytes(64, 1'b1);
        build(MY_MAC, 48'h02_00_00_00_00_BB, 16'h86DD, 46);
        for (int i = 14; i < 60; i++) frm[i] = 8'(8'hA0 + i);
        begin
            logic [31:0] f;
            for (int i = 0; i < 4; i++) void'(frm.pop_back());
            f = ~model_crc(frm.size());
            for (int i = 0; i < 4; i++) frm.push_back(f[i*8 +: 8]);
        end
        expect_frame();
        send_bytes(64, 1'b0); frame_active = 1'b0;
        drain("b2b");

        // Foreign unicast DA: filtered only when the feature is built in.
        build(48'h02_00_00_00_00_02, 48'h02_00_00_00_00_AA, 16'h0800, 46);
        expect_frame();
        send_bytes(64, 1'b0); frame_active = 1'b0;
        drain("foreign_da");

        // Local DA is always accepted.
        build(MY_MAC, 48'h02_00_00_00_00_AA, 16'h0800, 50);
        expect_frame();
        send_bytes(68, 1'b0); frame_active = 1'b0;
        drain("local_da");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ethernet_frame_parser.md
Name: ethernet_frame_parser

Overview:
Consumes the byte stream from the MII receive stage (post-SFD bytes plus frame-active level) on eth_rx_clk.
- Splits each frame into Ethernet II header fields and a payload stream, with the 4-byte FCS stripped.
- Checks CRC-32 and length, then reports a per-frame status pulse.
- Sits between the MII nibble-to-byte receiver and the future packet classifier / RX FIFO.

Parameters:
MAX_FRAME_LEN, 1518, largest legal frame in bytes (DA through FCS); longer frames are flagged oversize.
MIN_FRAME_LEN, 64, smallest legal frame in bytes including FCS; shorter frames are flagged runt.
LOCAL_MAC, 48'h02_00_00_00_00_01, station address; used only with ETH_MAC_FILTER_EN.

Ports:
eth_rx_clk  in  1  receive clock, all logic on rising edge
eth_rx_rst  in  1  asynchronous active-high reset
rx_byte  in  8  received frame byte (DA first)
rx_byte_valid  in  1  one-cycle strobe, rx_byte valid
frame_active  in  1  eth_rx_dv level; falling edge marks end of frame
dst_mac  out  48  destination address, first byte in [47:40]
src_mac  out  48  source address, first byte in [47:40]
ethertype  out  16  type/length field, first byte in [15:8]
hdr_valid  out  1  one-cycle pulse: header fields updated
payload_byte  out  8  payload byte, FCS excluded
payload_valid  out  1  one-cycle strobe for payload_byte
frame_done  out  1  one-cycle end-of-frame pulse
frame_ok  out  1  qualifies frame_done: CRC good, length legal, not filtered
crc_err  out  1  qualifies frame_done: CRC residue mismatch
len_err  out  1  qualifies frame_done: runt or oversize
addr_miss  out  1  qualifies frame_done: rejected by MAC filter
frame_len  out  11  bytes received incl. FCS, saturating at MAX_FRAME_LEN+1

Behaviour:
Reset:
- All outputs 0; state IDLE; counters, CRC and delay line cleared.
- Reset mid-frame abandons the frame. No frame_done is issued for it.
- After reset, the parser waits for frame_active low before arming, so a partial frame is never parsed.

FSM, one state per byte-acceptance regime:
- IDLE: wait for first rx_byte_valid while frame_active=1 -> HEADER.
- HEADER: bytes 0-13 shift into dst_mac/src_mac/ethertype. On acceptance of byte 13, go to PAYLOAD; hdr_valid pulses the next cycle. Fields hold until the next frame's byte 13.
- PAYLOAD: every byte enters a 4-deep delay line. On accepting byte n (n>=18), byte n-4 is emitted the following cycle on payload_byte/payload_valid. The last 4 bytes (FCS) are never emitted. Pad bytes are emitted as payload.
- DONE: entered on frame_active falling edge detected at cycle t (frame_active=0, previous sample 1). A byte strobed at cycle t is still counted. frame_done pulses at t+1, then return to IDLE.

Frame status:
- Zero bytes received: no frame_done.
- Falling edge during HEADER: frame_done with len_err=1, and hdr_valid is never pulsed.
- Status bits valid only with frame_done; otherwise 0.

CRC:
- Reflected CRC-32, poly 0xEDB88320, init 0xFFFFFFFF, updated over every byte including FCS.
- Good frame: register equals residue 0xDEBB20E3 at end. crc_err = mismatch.

Length:
- Byte counter saturates at MAX_FRAME_LEN+1.
- len_err when frame_len < MIN_FRAME_LEN or frame_len > MAX_FRAME_LEN.
- Once the count exceeds MAX_FRAME_LEN, payload_valid is suppressed for the rest of the frame.

frame_ok = !crc_err && !len_err && !addr_miss.

Back-to-back frames: if frame_active rises in the frame_done cycle, the new frame is parsed normally. Counters and CRC clear on fall detection.

No backpressure: the downstream consumer must accept payload at line rate (at most 1 byte per 2 clocks).

Optional Feature:
ETH_MAC_FILTER_EN:
- Defined: once the header completes, dst_mac must equal LOCAL_MAC or FF:FF:FF:FF:FF:FF. Otherwise payload_valid is suppressed for the whole frame, and frame_done is still issued with addr_miss=1, frame_ok=0.
- Undefined: no comparison; addr_miss tied 0; all payload emitted.

Decomposition:
Package eth_pkg holds:
- parser state enum
- ETH_HDR_LEN=14, ETH_FCS_LEN=4
- CRC32_POLY, CRC32_INIT, CRC32_RESIDUE
- ETH_BROADCAST_MAC

Sub-module eth_crc32 (byte-wide next-CRC combinational function with clear/enable register) is natural and reusable by the future TX path.

Test Plan:
- 64-byte frame, DA=FF..FF, SA=02:00:00:00:00:AA, type 0x0800, 46 payload bytes 0x00..0x2D, correct FCS -> hdr_valid once; payload 0x00..0x2D in order; frame_done with frame_ok=1, frame_len=64.
- Same frame with one payload bit flipped -> payload still streamed; frame_done with crc_err=1, frame_ok=0.
- 40-byte frame with valid FCS -> len_err=1, frame_len=40; 1519-byte frame -> len_err=1, no payload after byte 1518.
- frame_active falls after 10 bytes -> no hdr_valid; frame_done with len_err=1. Reset asserted mid-payload -> all outputs 0, no frame_done.
- Two legal frames with frame_active low for exactly 1 cycle between -> two frame_done pulses, both frame_ok=1, payloads not merged.
- ETH_MAC_FILTER_EN defined, DA=02:00:00:00:00:02 -> zero payload_valid; frame_done with addr_miss=1. DA=LOCAL_MAC -> frame_ok=1.
